// File: rtl/ext_unit_pkg.sv
// ---------------------------------------------------------------------------
// ext_unit_pkg
// Purpose : shared definitions for the immediate extender. The extend-op
//           encoding lives here so the decoder can produce it with the same
//           names the extender consumes.
// Contents: ext_op_e (EXT_ZERO / EXT_SIGN), default field widths.
// ---------------------------------------------------------------------------
package ext_unit_pkg;

    typedef enum logic {
        EXT_ZERO = 1'b0,
        EXT_SIGN = 1'b1
    } ext_op_e;

    localparam int EXT_IN_W_DEFAULT  = 16;
    localparam int EXT_OUT_W_DEFAULT = 32;

endpackage : ext_unit_pkg

// File: rtl/ext_unit_if.sv
// ---------------------------------------------------------------------------
// ext_unit_if
// Purpose : groups the operand/control and result signals of the immediate
//           extender. clk and rst_n are not part of the bundle.
// Signals : Op        1 = sign-extend, 0 = zero-extend
//           in        IN_W-bit field to extend
//           en        capture enable for the registered copy (0 = stall)
//           in_valid  qualifies in/Op for the registered copy
//           out       combinational extended value
//           out_q     registered extended value
//           out_valid registered copy of in_valid
// Modports: master drives the operand side, slave (the extender) drives results.
// ---------------------------------------------------------------------------
interface ext_unit_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32
);
    logic             Op;
    logic [IN_W-1:0]  in;
    logic             en;
    logic             in_valid;
    logic [OUT_W-1:0] out;
    logic [OUT_W-1:0] out_q;
    logic             out_valid;

    modport master (
        output Op, in, en, in_valid,
        input  out, out_q, out_valid
    );

    modport slave (
        input  Op, in, en, in_valid,
        output out, out_q, out_valid
    );
endinterface : ext_unit_if

// File: rtl/ext_comb.sv
// ---------------------------------------------------------------------------
// ext_comb
// Purpose : pure combinational immediate extender, IN_W -> OUT_W.
// Ports   : i_op   1      1 = sign-extend, 0 = zero-extend
//           i_in   IN_W   field to extend
//           o_out  OUT_W  extended value; o_out[IN_W-1:0] is always i_in
// ---------------------------------------------------------------------------
module ext_comb
    import ext_unit_pkg::*;
#(
    parameter int IN_W  = EXT_IN_W_DEFAULT,
    parameter int OUT_W = EXT_OUT_W_DEFAULT
) (
    input  logic             i_op,
    input  logic [IN_W-1:0]  i_in,
    output logic [OUT_W-1:0] o_out
);

    generate
        if (IN_W < 1 || OUT_W < IN_W) begin : g_bad_params
            $error("ext_comb: need IN_W >= 1 and OUT_W >= IN_W");
        end

        if (OUT_W == IN_W) begin : g_same_width
            // Nothing to fill: the result is the field itself for either op.
            assign o_out = i_in;
        end else begin : g_extend
            logic w_fill;
            // The op is ANDed with the field MSB, so an unknown op can only
            // disturb the fill bits, never the copied field bits.
            assign w_fill = (i_op == EXT_SIGN) & i_in[IN_W-1];
            assign o_out  = {{(OUT_W-IN_W){w_fill}}, i_in};
        end
    endgenerate

endmodule : ext_comb

// File: rtl/ext_unit.sv
// ---------------------------------------------------------------------------
// ext_unit
// Purpose : immediate extender for the execute stage. Provides a zero-latency
//           extended operand for the ALU B-operand mux and a registered copy
//           with a valid flag for stages that capture the operand.
// Ports   : clk    single clock, state updates on the rising edge
//           rst_n  asynchronous active-low reset (clears out_q / out_valid)
//           bus    ext_unit_if.slave: Op, in, en, in_valid -> out, out_q,
//                  out_valid
// ---------------------------------------------------------------------------
module ext_unit
    import ext_unit_pkg::*;
#(
    parameter int IN_W  = EXT_IN_W_DEFAULT,
    parameter int OUT_W = EXT_OUT_W_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    ext_unit_if.slave  bus
);

    logic [OUT_W-1:0] w_out;
    logic [OUT_W-1:0] r_out_q;
    logic             r_out_valid;

    ext_comb #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_ext_comb (
        .i_op  (bus.Op),
        .i_in  (bus.in),
        .o_out (w_out)
    );

    // Capture stage. out_q is loaded whenever en is high, independent of
    // in_valid; out_valid tells the consumer whether the captured value means
    // anything. en low is a stall and holds both.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_q     <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.en) begin
            r_out_q     <= w_out;
            r_out_valid <= bus.in_valid;
        end
    end

    // The combinational result does not pass through reset, so the ALU path
    // stays usable while the pipeline is held in reset.
    assign bus.out       = w_out;
    assign bus.out_q     = r_out_q;
    assign bus.out_valid = r_out_valid;

endmodule : ext_unit

// File: tb/tb_ext_unit.sv
// ---------------------------------------------------------------------------
// tb_ext_unit
// Directed test of ext_unit: default 16->32 instance plus 8->32 and 16->16
// instances for the width corner cases. All instances share clk and rst_n.
// ---------------------------------------------------------------------------
module tb_ext_unit;

    logic clk;
    logic rst_n;

    int n_vec;
    int n_err;

    ext_unit_if #(.IN_W(16), .OUT_W(32)) bus ();
    ext_unit_if #(.IN_W(8),  .OUT_W(32)) bus8 ();
    ext_unit_if #(.IN_W(16), .OUT_W(16)) bus16 ();

    ext_unit #(.IN_W(16), .OUT_W(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    ext_unit #(.IN_W(8), .OUT_W(32)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    ext_unit #(.IN_W(16), .OUT_W(16)) dut16 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %h expected %h", n_vec, tag, obs, exp);
    endtask

    logic [15:0] rnd_in;
    logic        rnd_op;
    logic [31:0] rnd_exp;
    logic [31:0] prev_exp;

    initial begin
        n_vec = 0;
        n_err = 0;

        // ---- reset state and combinational path during reset ----
        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.in_valid = 1'b1;
        bus.Op       = 1'b1;
        bus.in       = 16'h8000;
        bus8.en = 1'b0; bus8.in_valid = 1'b0; bus8.Op = 1'b0; bus8.in = 8'h00;
        bus16.en = 1'b0; bus16.in_valid = 1'b0; bus16.Op = 1'b0; bus16.in = 16'h0000;
        #2;
        chk("rst_out_q",     bus.out_q, 32'h0);
        chk("rst_out_valid", {31'b0, bus.out_valid}, 32'h0);
        chk("sx_8000",       bus.out, 32'hFFFF_8000);
        bus.Op = 1'b0; #1;
        chk("zx_8000",       bus.out, 32'h0000_8000);
        bus.Op = 1'b1; bus.in = 16'h7FFF; #1;
        chk("sx_7fff",       bus.out, 32'h0000_7FFF);
        bus.in = 16'hFFFF; #1;
        chk("sx_ffff",       bus.out, 32'hFFFF_FFFF);
        bus.Op = 1'b0; #1;
        chk("zx_ffff",       bus.out, 32'h0000_FFFF);

        // Clock edge while reset is held must not capture.
        @(posedge clk); #1;
        chk("rst_hold_q",    bus.out_q, 32'h0);

        // ---- first capture after release ----
        @(negedge clk);
        rst_n = 1'b1;
        bus.en = 1'b1; bus.in_valid = 1'b1; bus.Op = 1'b1; bus.in = 16'h8001;
        @(posedge clk); #1;
        chk("cap_8001_q",     bus.out_q, 32'hFFFF_8001);
        chk("cap_8001_valid", {31'b0, bus.out_valid}, 32'h1);

        // ---- asynchronous reset mid-cycle ----
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_q",     bus.out_q, 32'h0);
        chk("async_rst_valid", {31'b0, bus.out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---- stall ----
        bus.en = 1'b1; bus.in_valid = 1'b1; bus.Op = 1'b0; bus.in = 16'h1234;
        @(posedge clk); #1;
        chk("stall_cap_q",     bus.out_q, 32'h0000_1234);
        chk("stall_cap_valid", {31'b0, bus.out_valid}, 32'h1);
        bus.en = 1'b0; bus.in_valid = 1'b0; bus.in = 16'hABCD;
        @(posedge clk); #1;
        chk("stall_hold_q",     bus.out_q, 32'h0000_1234);
        chk("stall_hold_valid", {31'b0, bus.out_valid}, 32'h1);
        chk("stall_out_zx",     bus.out, 32'h0000_ABCD);
        bus.Op = 1'b1; #1;
        chk("stall_out_sx",     bus.out, 32'hFFFF_ABCD);

        // ---- capture with in_valid low: data loads, valid drops ----
        bus.en = 1'b1;
        @(posedge clk); #1;
        chk("inv_cap_q",     bus.out_q, 32'hFFFF_ABCD);
        chk("inv_cap_valid", {31'b0, bus.out_valid}, 32'h0);

        // ---- unknown op must not reach the copied field bits ----
        bus.Op = 1'bx; bus.in = 16'h9234; #1;
        chk("xop_low_9234", {16'h0, bus.out[15:0]}, 32'h0000_9234);
        bus.in = 16'h0055; #1;
        chk("xop_low_0055", {16'h0, bus.out[15:0]}, 32'h0000_0055);

        // ---- width corner cases ----
        bus8.Op = 1'b1; bus8.in = 8'h80; #1;
        chk("w8_sx_80",  bus8.out, 32'hFFFF_FF80);
        bus8.Op = 1'b0; #1;
        chk("w8_zx_80",  bus8.out, 32'h0000_0080);
        bus8.Op = 1'b1; bus8.in = 8'h7F; #1;
        chk("w8_sx_7f",  bus8.out, 32'h0000_007F);
        bus16.Op = 1'b1; bus16.in = 16'h8000; #1;
        chk("w16_sx",    {16'h0, bus16.out}, 32'h0000_8000);
        bus16.Op = 1'b0; #1;
        chk("w16_zx",    {16'h0, bus16.out}, 32'h0000_8000);

        // ---- short random run: out now, out_q one edge later ----
        bus.en = 1'b1; bus.in_valid = 1'b1;
        @(negedge clk);
        prev_exp = 32'h0;
        for (int i = 0; i < 40; i++) begin
            rnd_in  = 16'($urandom);
            rnd_op  = 1'($urandom_range(0, 1));
            rnd_exp = rnd_op ? 32'($signed(rnd_in)) : 32'(rnd_in);
            bus.Op = rnd_op; bus.in = rnd_in;
            #1;
            chk("rnd_out", bus.out, rnd_exp);
            if (i > 0) chk("rnd_out_q", bus.out_q, prev_exp);
            prev_exp = rnd_exp;
            @(negedge clk);
        end
        chk("rnd_out_q_last", bus.out_q, prev_exp);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_ext_unit
